// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer. Owns the program counter, chooses the
// next PC (exception > ERET > buffered branch > branch > pc+4), holds the PC
// under stall, and buffers a branch redirect that arrives while stalled.
// Optional feature macro: PC_ADEL_CHECK_EN enables the fetch address error
// check (misaligned PC suppresses the fetch and raises adel_f).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        exc_flush,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_f,
    output logic        pc_valid,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    output logic        adel_f
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2,
        HOLD_PEND = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        fetching;
    logic        misaligned;

    // State, PC and pending-branch registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Next-state / next-PC selection, including stall hold and branch buffering.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;

        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (exc_flush) begin
            pc_d       = EXC_VECTOR;
            pend_vld_d = 1'b0;
            state_d    = RUN;
        end else if (eret) begin
            pc_d       = epc;
            pend_vld_d = 1'b0;
            state_d    = RUN;
        end else if (!stall_f) begin
            if (pend_vld_q) begin
                pc_d = pend_tgt_q;
            end else if (br_taken) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            pend_vld_d = 1'b0;
            state_d    = RUN;
        end else begin
            // Stalled: PC holds; only the first branch seen is kept.
            if (br_taken && !pend_vld_q) begin
                pend_tgt_d = br_target;
                pend_vld_d = 1'b1;
                state_d    = HOLD_PEND;
            end else if (pend_vld_q) begin
                state_d = HOLD_PEND;
            end else begin
                state_d = HOLD;
            end
        end
    end

    assign fetching = (state_q != IDLE);

`ifdef PC_ADEL_CHECK_EN
    // A misaligned PC is still presented (as BadVAddr) but not fetched.
    assign misaligned = fetching && (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign pc_f           = pc_q;
    assign inst_sram_addr = pc_q;
    assign adel_f         = misaligned;
    assign pc_valid       = fetching && !misaligned;
    assign inst_sram_en   = fetching && !misaligned;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector bench for pc_fetch_ctrl. Each vector's
// inputs are applied for one clock; outputs are compared 1 time unit after
// that rising edge. A hand-written sequence follows for a long stall.
module tb_pc_fetch_ctrl;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          exc;
        bit          eret;
        logic [31:0] epc;
        bit          br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        bit          exp_run;   // 0 while the block sits in IDLE
    } vec_t;

`ifdef PC_ADEL_CHECK_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_f = 1'b0;
    logic        exc_flush = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] pc_f;
    logic        pc_valid;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic        adel_f;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side record of a buffered branch, used to flag illegal stimulus.
    bit tb_pend = 1'b0;

    vec_t vecs[$];

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .exc_flush      (exc_flush),
        .eret           (eret),
        .epc            (epc),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .pc_f           (pc_f),
        .pc_valid       (pc_valid),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .adel_f         (adel_f)
    );

    always #5 clk = ~clk;

    // A second branch while one is already buffered is illegal stimulus.
    always @(posedge clk) begin
        if (rst || exc_flush || eret || !stall_f) begin
            tb_pend <= 1'b0;
        end else if (br_taken) begin
            assert (!tb_pend) else $error("illegal stimulus: branch while pending");
            tb_pend <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        stall_f   = v.stall;
        exc_flush = v.exc;
        eret      = v.eret;
        epc       = v.epc;
        br_taken  = v.br;
        br_target = v.tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] exp_pc, input bit exp_run);
        bit exp_adel;
        exp_adel = ADEL_EN && exp_run && (exp_pc[1:0] != 2'b00);
        check({tag, " pc_f"}, pc_f, exp_pc);
        check({tag, " addr"}, inst_sram_addr, exp_pc);
        check({tag, " en"}, {31'b0, inst_sram_en}, {31'b0, exp_run && !exp_adel});
        check({tag, " valid"}, {31'b0, pc_valid}, {31'b0, exp_run && !exp_adel});
        check({tag, " adel"}, {31'b0, adel_f}, {31'b0, exp_adel});
    endtask

    function automatic vec_t mk(bit r, bit s, bit x, bit e, logic [31:0] ep,
                                bit b, logic [31:0] t, logic [31:0] xp, bit run);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = x; v.eret = e; v.epc = ep;
        v.br = b; v.tgt = t; v.exp_pc = xp; v.exp_run = run;
        return v;
    endfunction

    initial begin
        vec_t seq;

        //                r  s  x  e  epc           b  tgt           exp_pc        run
        // reset held two cycles, one IDLE cycle, then sequential fetch
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00008, 1));
        // branch with no stall
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80001000, 32'h80001000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80001004, 1));
        // three-cycle stall, branch buffered in the first stall cycle
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h80002000, 32'h80001004, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h80001004, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h80001004, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80002000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80002004, 1));
        // exc + eret + branch under stall: exception wins, nothing buffered
        vecs.push_back(mk(0, 1, 1, 1, 32'h80000100, 1, 32'h80003000, 32'hbfc00380, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00380, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00384, 1));
        // eret alone under stall
        vecs.push_back(mk(0, 1, 0, 1, 32'h80000100, 0, 32'h0,        32'h80000100, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80000104, 1));
        // +4 wraps modulo 2^32
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'hfffffffc, 32'hfffffffc, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 1));
        // buffered target beats a fresh branch at release
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h80004000, 32'h00000004, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80005000, 32'h80004000, 1));
        // branch in the release cycle with nothing buffered: applied directly
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h80004000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80006000, 32'h80006000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80006004, 1));
        // reset mid-stall discards the buffered branch
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h80007000, 32'h80006004, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1));
        // misaligned branch target, then back to an aligned one
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80000002, 32'h80000002, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h80000006, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80000100, 32'h80000100, 1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_run);
        end

        // Hand sequence: exc+eret without stall, then a long stall with a
        // branch buffered on its first cycle; address must stay put throughout.
        seq = mk(0, 0, 1, 1, 32'h80000200, 0, 32'h0, 32'hbfc00380, 1);
        drive(seq);
        check_outputs("seq_exc_eret", 32'hbfc00380, 1'b1);
        seq = mk(0, 1, 0, 0, 32'h0, 1, 32'h80008000, 32'hbfc00380, 1);
        drive(seq);
        check_outputs("seq_stall0", 32'hbfc00380, 1'b1);
        for (int k = 1; k < 4; k++) begin
            seq = mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'hbfc00380, 1);
            drive(seq);
            check_outputs($sformatf("seq_stall%0d", k), 32'hbfc00380, 1'b1);
        end
        seq = mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h80008000, 1);
        drive(seq);
        check_outputs("seq_release", 32'h80008000, 1'b1);
        drive(seq);
        check_outputs("seq_next", 32'h80008004, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
